// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, used by the sync
// generator and by the renderer for its screen limits.
package vga_timing_pkg;

   localparam int COORD_W   = 10;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START  = H_DISPLAY + H_FRONT;
   localparam int HS_END    = HS_START + H_SYNC - 1;
   localparam int VS_START  = V_DISPLAY + V_FRONT;
   localparam int VS_END    = VS_START + V_SYNC - 1;

   function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle from the sync generator to the renderer / connector.
interface vga_sync_if;
   import vga_timing_pkg::*;

   logic               hsync;
   logic               vsync;
   logic               videoOn;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               pixelTick;
   logic               frameStart;

   modport master (output hsync, vsync, videoOn, x, y, pixelTick, frameStart);
   modport slave  (input  hsync, vsync, videoOn, x, y, pixelTick, frameStart);

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// Divides the board clock down to a one-clk pixel enable every CLK_DIV clocks.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic pixelTick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
      $error("pixel_tick_gen: CLK_DIV must be in 1..16");
   end

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk) begin
      if (reset)
         div <= '0;
      else if (div == DIV_LAST)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so every clk is a tick.
   assign pixelTick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel enable, x/y counters, visible flag, frame pulse,
// and hsync/vsync registered one clk behind x/y to match the renderer's rgb.
module vga_sync
   import vga_timing_pkg::COORD_W;
   import vga_timing_pkg::in_range;
#(
   parameter int CLK_DIV     = 4,
   parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BACK      = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BACK      = vga_timing_pkg::V_BACK,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   vga_sync_if.master  vga
);

   localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_size_check
      $error("vga_sync: timing totals exceed the 10-bit counter range");
   end

   logic               tick;
   logic               line_end;
   logic [COORD_W-1:0] h_count;
   logic [COORD_W-1:0] v_count;
   logic               hsync_q;
   logic               vsync_q;
   logic               frame_q;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk       (clk),
      .reset     (reset),
      .pixelTick (tick)
   );

   assign line_end = tick && (h_count == H_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
         hsync_q <= !SYNC_ACTIVE;
         vsync_q <= !SYNC_ACTIVE;
         frame_q <= 1'b0;
      end else begin
         // Sync levels come from the pre-update counters: one clk behind x/y.
         hsync_q <= in_range(h_count, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
         vsync_q <= in_range(v_count, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : !SYNC_ACTIVE;
         frame_q <= line_end && (v_count == V_LAST);
         if (tick)
            h_count <= line_end ? '0 : h_count + 1'b1;
         if (line_end)
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
   end

   assign vga.x          = h_count;
   assign vga.y          = v_count;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.frameStart = frame_q;
   assign vga.pixelTick  = tick;
   assign vga.videoOn    = !reset && (h_count < H_VIS) && (v_count < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: three parameterisations compared every clk against an
// arithmetic model driven by the number of clocks since reset was released.
module tb_vga_sync;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_sync_if ifa ();
   vga_sync_if ifb ();
   vga_sync_if ifc ();

   // Standard 640x480 timing, 4 clocks per pixel, active-low syncs.
   vga_sync dut_a (
      .clk   (clk),
      .reset (reset),
      .vga   (ifa)
   );

   // Shrunken raster so several full frames fit in a short run.
   vga_sync #(
      .CLK_DIV (3),
      .H_DISPLAY (20), .H_FRONT (3), .H_SYNC (5), .H_BACK (4),
      .V_DISPLAY (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
      .SYNC_ACTIVE (1'b0)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .vga   (ifb)
   );

   // One clock per pixel, active-high syncs, full-width lines, short frame.
   vga_sync #(
      .CLK_DIV (1),
      .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .SYNC_ACTIVE (1'b1)
   ) dut_c (
      .clk   (clk),
      .reset (reset),
      .vga   (ifc)
   );

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       pt;
      logic       fs;
   } exp_t;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at clk %0d after reset: got %0h, expected %0h", tag, k, got, exp);
      end
   endtask

   // Clock kk after reset release: kk/d pixels have elapsed.
   function automatic exp_t model(input int kk, input int d,
                                  input int hd, input int hf, input int hsw, input int hb,
                                  input int vd, input int vf, input int vsw, input int vb,
                                  input bit act, input bit rst);
      int ht = hd + hf + hsw + hb;
      int vt = vd + vf + vsw + vb;
      int p  = kk / d;
      int q;
      int hx;
      int vy;
      exp_t e;
      e.x  = 10'(p % ht);
      e.y  = 10'((p / ht) % vt);
      e.pt = ((kk % d) == d - 1);
      e.vo = !rst && ((p % ht) < hd) && (((p / ht) % vt) < vd);
      e.fs = (kk > 0) && ((kk % d) == 0) && ((p % (ht * vt)) == 0);
      if (kk == 0) begin
         e.hs = !act;
         e.vs = !act;
      end else begin
         q  = (kk - 1) / d;
         hx = q % ht;
         vy = (q / ht) % vt;
         e.hs = (hx >= hd + hf && hx < hd + hf + hsw) ? act : !act;
         e.vs = (vy >= vd + vf && vy < vd + vf + vsw) ? act : !act;
      end
      return e;
   endfunction

   task automatic check_dut(input string name, input exp_t e,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic vo,
                            input logic pt, input logic fs);
      chk({name, ".x"},          32'(x),  32'(e.x));
      chk({name, ".y"},          32'(y),  32'(e.y));
      chk({name, ".hsync"},      32'(hs), 32'(e.hs));
      chk({name, ".vsync"},      32'(vs), 32'(e.vs));
      chk({name, ".videoOn"},    32'(vo), 32'(e.vo));
      chk({name, ".pixelTick"},  32'(pt), 32'(e.pt));
      chk({name, ".frameStart"}, 32'(fs), 32'(e.fs));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) k = 0;
      else       k++;
      @(negedge clk);
      check_dut("a", model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, reset),
                ifa.x, ifa.y, ifa.hsync, ifa.vsync, ifa.videoOn, ifa.pixelTick, ifa.frameStart);
      check_dut("b", model(k, 3, 20, 3, 5, 4, 12, 2, 2, 3, 1'b0, reset),
                ifb.x, ifb.y, ifb.hsync, ifb.vsync, ifb.videoOn, ifb.pixelTick, ifb.frameStart);
      check_dut("c", model(k, 1, 640, 16, 96, 48, 4, 1, 2, 1, 1'b1, reset),
                ifc.x, ifc.y, ifc.hsync, ifc.vsync, ifc.videoOn, ifc.pixelTick, ifc.frameStart);
   endtask

   initial begin
      int run_len;
      int hold_len;
      reset = 1'b1;
      repeat (10) cycle();
      reset = 1'b0;
      // Long uninterrupted run: several lines of dut_a, multiple frames of b and c.
      repeat (14000) cycle();
      // Reset pulses landing at random points in the raster and divider phase.
      for (int i = 0; i < 20; i++) begin
         run_len  = int'($urandom_range(50, 2000));
         hold_len = int'($urandom_range(1, 3));
         repeat (run_len) cycle();
         reset = 1'b1;
         repeat (hold_len) cycle();
         reset = 1'b0;
      end
      repeat (300) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
